// File: rtl/i2c_slave_byte_if.sv
// I2C slave bit engine: filtered SCL/SDA, START/STOP detect,
// address match and byte shift with byte strobes to the bridge.
module i2c_slave_byte_if #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  input  logic       slave_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       data_avail,
  output logic       data_req,
  output logic       start_signal,
  output logic       stop_signal,
  output logic       slave_act
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6,
    WAIT     = 3'd7
  } state_t;

  logic [1:0]    scl_s, sda_s;
  logic          scl_f, sda_f;
  logic          scl_d, sda_d;
  logic [CW-1:0] scl_c, sda_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      scl_c <= '0;
      sda_c <= '0;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_d <= scl_f;
      sda_d <= sda_f;
      // a new level must persist FILTER_LEN cycles to pass
      if (scl_s[1] == scl_f) begin
        scl_c <= '0;
      end else if (scl_c == CMAX) begin
        scl_f <= scl_s[1];
        scl_c <= '0;
      end else begin
        scl_c <= scl_c + 1'b1;
      end
      if (sda_s[1] == sda_f) begin
        sda_c <= '0;
      end else if (sda_c == CMAX) begin
        sda_f <= sda_s[1];
        sda_c <= '0;
      end else begin
        sda_c <= sda_c + 1'b1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state, state_n;
  logic [7:0] shift, shift_n, dout_n;
  logic [3:0] cnt, cnt_n;
  logic       rw, rw_n, oen, oen_n, act, act_n;
  logic       avail_n, req_n, sta_n, sto_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      shift        <= '0;
      cnt          <= '0;
      rw           <= 1'b0;
      dout         <= '0;
      oen          <= 1'b1;
      act          <= 1'b0;
      data_avail   <= 1'b0;
      data_req     <= 1'b0;
      start_signal <= 1'b0;
      stop_signal  <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      cnt          <= cnt_n;
      rw           <= rw_n;
      dout         <= dout_n;
      oen          <= oen_n;
      act          <= act_n;
      data_avail   <= avail_n;
      data_req     <= req_n;
      start_signal <= sta_n;
      stop_signal  <= sto_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    rw_n    = rw;
    dout_n  = dout;
    oen_n   = oen;
    act_n   = act;
    avail_n = 1'b0;
    req_n   = 1'b0;
    sta_n   = 1'b0;
    sto_n   = 1'b0;
    if (!slave_en) begin
      state_n = IDLE;
      oen_n   = 1'b1;
      act_n   = 1'b0;
      cnt_n   = '0;
    end else if (stop_det) begin
      state_n = IDLE;
      oen_n   = 1'b1;
      act_n   = 1'b0;
      cnt_n   = '0;
      sto_n   = 1'b1;
    end else if (start_det) begin
      state_n = ADDR;
      oen_n   = 1'b1;
      act_n   = 1'b0;
      cnt_n   = '0;
      sta_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE, WAIT: begin
        end
        ADDR, RX: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_f};
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = '0;
              if (state == RX) begin
                dout_n  = shift_n;
                avail_n = 1'b1;
                state_n = RX_ACK;
              end else if (shift[6:0] == SLAVE_ADDR) begin
                rw_n    = sda_f;
                state_n = ADDR_ACK;
              end else begin
                state_n = WAIT;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          // cnt=0: waiting for the fall that opens the ACK clock
          if (scl_rise && cnt == 4'd1 && state == ADDR_ACK && rw)
            req_n = 1'b1;
          if (scl_fall) begin
            if (cnt == 4'd0) begin
              oen_n = 1'b0;
              act_n = 1'b1;
              cnt_n = 4'd1;
            end else begin
              cnt_n = '0;
              if (state == ADDR_ACK && rw) begin
                shift_n = din;
                oen_n   = din[7];
                state_n = TX;
              end else begin
                oen_n   = 1'b1;
                state_n = RX;
              end
            end
          end
        end
        TX: begin
          if (scl_rise)
            cnt_n = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oen_n   = 1'b1;
              cnt_n   = '0;
              state_n = TX_ACK;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              oen_n   = shift[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              req_n = 1'b1;
              cnt_n = 4'd1;
            end else begin
              act_n   = 1'b0;
              state_n = WAIT;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            shift_n = din;
            oen_n   = din[7];
            cnt_n   = '0;
            state_n = TX;
          end
        end
      endcase
    end
  end

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen;
  assign slave_act    = act;

endmodule

// File: tb/tb_i2c_slave_byte_if.sv
// Directed bench for i2c_slave_byte_if: bus-level master model
// with a vector table of write transactions plus corner sequences.
module tb_i2c_slave_byte_if;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       en = 1'b1;
  logic [7:0] din = 8'h00;
  logic       scl_i, sda_i;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [7:0] dout;
  logic       data_avail, data_req, start_signal, stop_signal;
  logic       slave_act;

  assign scl_i = scl_m;
  assign sda_i = sda_m & sda_padoen_o;

  always #5 clk = ~clk;

  i2c_slave_byte_if dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .slave_en     (en),
    .din          (din),
    .dout         (dout),
    .data_avail   (data_avail),
    .data_req     (data_req),
    .start_signal (start_signal),
    .stop_signal  (stop_signal),
    .slave_act    (slave_act)
  );

  int n_avail = 0, n_req = 0, n_sta = 0, n_sto = 0;
  int n_low = 0, n_act = 0, rd_idx = 0;
  logic [7:0] got[$];
  logic [7:0] rd_bytes [3] = '{8'h5A, 8'hC3, 8'h3C};

  initial begin
    logic po, pa;
    po = 1'b1;
    pa = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (data_avail) begin
        n_avail++;
        got.push_back(dout);
      end
      if (data_req) begin
        n_req++;
        din = rd_bytes[rd_idx % 3];
        rd_idx++;
      end
      if (start_signal) n_sta++;
      if (stop_signal) n_sto++;
      if (po && !sda_padoen_o) n_low++;
      if (!pa && slave_act) n_act++;
      po = sda_padoen_o;
      pa = slave_act;
    end
  end

  int ntests = 0, nfail = 0;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    r = sda_i;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic send_start();
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic send_stop();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clk_bit(nack, r);
  endtask

  typedef struct {
    logic [7:0] addr;
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    int         acks;
    int         avail;
    logic [7:0] last;
    int         act;
  } vec_t;

  vec_t vt[4];

  task automatic run_vec(input vec_t v, input string tag);
    int b_av, b_req, b_sta, b_sto, b_low, b_act, acks;
    logic a;
    b_av  = n_avail;
    b_req = n_req;
    b_sta = n_sta;
    b_sto = n_sto;
    b_low = n_low;
    b_act = n_act;
    acks  = 0;
    send_start();
    write_byte(v.addr, a);
    acks += a ? 1 : 0;
    write_byte(v.d0, a);
    acks += a ? 1 : 0;
    if (v.nb > 1) begin
      write_byte(v.d1, a);
      acks += a ? 1 : 0;
    end
    send_stop();
    wq();
    check({tag, "_acks"}, acks, v.acks);
    check({tag, "_drives"}, n_low - b_low, v.acks);
    check({tag, "_avail"}, n_avail - b_av, v.avail);
    check({tag, "_dout"}, int'(dout), int'(v.last));
    check({tag, "_start"}, n_sta - b_sta, 1);
    check({tag, "_stop"}, n_sto - b_sto, 1);
    check({tag, "_act"}, n_act - b_act, v.act);
    check({tag, "_req"}, n_req - b_req, 0);
    if (v.avail == 2)
      check({tag, "_first"}, int'(got[got.size() - 2]), int'(v.d0));
  endtask

  initial begin
    logic a;
    logic [7:0] d;
    int b_av, b_req, b_sta, b_sto, b_low, b_act;

    vt[0] = '{8'hA0, 2, 8'h12, 8'h34, 3, 2, 8'h34, 1};
    vt[1] = '{8'hA2, 1, 8'h55, 8'h00, 0, 0, 8'h34, 0};
    vt[2] = '{8'hA0, 2, 8'hFF, 8'h00, 3, 2, 8'h00, 1};
    vt[3] = '{8'h20, 2, 8'h77, 8'h88, 0, 0, 8'h00, 0};

    repeat (5) @(posedge clk);
    #1;
    check("rst_oen", int'(sda_padoen_o), 1);
    check("rst_dout", int'(dout), 0);
    check("rst_act", int'(slave_act), 0);
    check("rst_state", int'(dut.state), 0);
    check("scl_oen", int'(scl_padoen_o), 1);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    // read: ACK first byte, NACK second
    b_req = n_req;
    send_start();
    write_byte(8'hA1, a);
    check("rd_addr_ack", int'(a), 1);
    read_byte(1'b0, d);
    check("rd_byte0", int'(d), 8'h5A);
    read_byte(1'b1, d);
    check("rd_byte1", int'(d), 8'hC3);
    check("rd_state_wait", int'(dut.state), 7);
    check("rd_oen", int'(sda_padoen_o), 1);
    check("rd_act", int'(slave_act), 0);
    check("rd_req", n_req - b_req, 2);
    send_stop();
    wq();

    // random read via repeated START
    b_av  = n_avail;
    b_req = n_req;
    b_sta = n_sta;
    b_sto = n_sto;
    send_start();
    write_byte(8'hA0, a);
    write_byte(8'h07, a);
    check("rr_wr_ack", int'(a), 1);
    send_start();
    write_byte(8'hA1, a);
    check("rr_rd_ack", int'(a), 1);
    read_byte(1'b1, d);
    check("rr_byte", int'(d), 8'h3C);
    send_stop();
    wq();
    check("rr_avail", n_avail - b_av, 1);
    check("rr_dout", int'(dout), 8'h07);
    check("rr_start", n_sta - b_sta, 2);
    check("rr_stop", n_sto - b_sto, 1);
    check("rr_req", n_req - b_req, 1);

    // 1- and 2-cycle SDA glitches while SCL high
    b_sta = n_sta;
    b_sto = n_sto;
    for (int w = 1; w <= 2; w++) begin
      sda_m = 1'b0;
      repeat (w) @(posedge clk);
      #1;
      sda_m = 1'b1;
      repeat (20) @(posedge clk);
      #1;
    end
    check("gl_start", n_sta - b_sta, 0);
    check("gl_stop", n_sto - b_sto, 0);
    check("gl_state", int'(dut.state), 0);

    // slave disabled: no pulses, no ACK
    en = 1'b0;
    b_av  = n_avail;
    b_sta = n_sta;
    b_sto = n_sto;
    b_low = n_low;
    b_act = n_act;
    send_start();
    write_byte(8'hA0, a);
    check("dis_ack", int'(a), 0);
    write_byte(8'h12, a);
    send_stop();
    wq();
    check("dis_start", n_sta - b_sta, 0);
    check("dis_stop", n_sto - b_sto, 0);
    check("dis_drives", n_low - b_low, 0);
    check("dis_avail", n_avail - b_av, 0);
    check("dis_act", n_act - b_act, 0);
    en = 1'b1;
    wq();

    // reset while the address ACK is being driven
    send_start();
    for (int i = 7; i >= 0; i--) clk_bit(vt[0].addr[i], a);
    sda_m = 1'b1;
    wq();
    check("ra_drive", int'(sda_padoen_o), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ra_release", int'(sda_padoen_o), 1);
    check("ra_act", int'(slave_act), 0);
    rst = 1'b0;
    scl_m = 1'b1;
    wq();
    scl_m = 1'b0;
    wq();
    send_stop();
    wq();
    run_vec(vt[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
